// File: rtl/calc_operand_ctrl.sv
// Operand sequencer for an external 4-bit adder: two button loads, one add pulse, sum capture.
// Define ACCUM_EN to chain a new operand onto the previous sum from DONE.
module calc_operand_ctrl #(
    parameter int ADD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       cin_sw,
    input  logic       load_btn,
    input  logic       clear_btn,
    input  logic [4:0] q_in,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       cin_out,
    output logic       add_en,
    output logic [4:0] result,
    output logic       result_valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int CW = $clog2(ADD_LATENCY + 2);
    localparam logic [CW-1:0] LAT = CW'(ADD_LATENCY);

    logic [1:0] ld_sync_q;
    logic [1:0] clr_sync_q;
    logic       ld_prev_q;
    logic       clr_prev_q;
    logic [2:0] arm_q;
    logic       load_ev;
    logic       clear_ev;

    state_e        state_q;
    logic [3:0]    a_q;
    logic [3:0]    b_q;
    logic          cin_q;
    logic          add_en_q;
    logic [4:0]    result_q;
    logic          valid_q;
    logic [CW-1:0] cnt_q;

    // arm_q holds off edge detection until the pipeline has seen real
    // button levels, so a button held through reset cannot fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_sync_q  <= '0;
            clr_sync_q <= '0;
            ld_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
            arm_q      <= '0;
        end else begin
            ld_sync_q  <= {ld_sync_q[0], load_btn};
            clr_sync_q <= {clr_sync_q[0], clear_btn};
            ld_prev_q  <= ld_sync_q[1];
            clr_prev_q <= clr_sync_q[1];
            arm_q      <= {arm_q[1:0], 1'b1};
        end
    end

    assign load_ev  = ld_sync_q[1] & ~ld_prev_q & arm_q[2];
    assign clear_ev = clr_sync_q[1] & ~clr_prev_q & arm_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            add_en_q <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (clear_ev) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            add_en_q <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            add_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_ev) begin
                        a_q     <= sw;
                        state_q <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (load_ev) begin
                        b_q      <= sw;
                        cin_q    <= cin_sw;
                        add_en_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == LAT) begin
                        result_q <= q_in;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (load_ev) begin
`ifdef ACCUM_EN
                        a_q      <= result_q[3:0];
                        b_q      <= sw;
                        cin_q    <= cin_sw;
                        valid_q  <= 1'b0;
                        add_en_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= EXEC;
`else
                        a_q     <= sw;
                        valid_q <= 1'b0;
                        state_q <= HAVE_A;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign cin_out      = cin_q;
    assign add_en       = add_en_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign state        = state_q;

endmodule
